// File: rtl/ibus_fetch_responder_pkg.sv
// Shared bus types and constants for the instruction-fetch responder.
package ibus_fetch_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] MSIZE8         = 3'b011;

  typedef enum logic [1:0] {IDLE, RESP, REFILL} fetch_state_t;

endpackage

// File: rtl/fetch_line_buf.sv
// Single-line fetch buffer: beat storage, line tag and valid bit, 32-bit word read mux.
module fetch_line_buf #(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned TAG_W      = 59,
  parameter int unsigned IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tag_load,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             valid_clr,
  input  logic             valid_set,
  input  logic             beat_we,
  input  logic [IDX_W-1:0] beat_widx,
  input  logic [63:0]      beat_wdata,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_sel,
  output logic [31:0]      rd_word,
  output logic [TAG_W-1:0] line_tag,
  output logic             line_valid
);

  logic [63:0] beats [LINE_BEATS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_tag   <= '0;
      line_valid <= 1'b0;
    end else begin
      if (tag_load) line_tag <= tag_in;
      if (valid_clr) begin
        line_valid <= 1'b0;
      end else if (valid_set) begin
        line_valid <= 1'b1;
      end
    end
  end

  // Data storage needs no reset: it is only read once line_valid is set.
  always_ff @(posedge clk) begin
    if (beat_we) beats[beat_widx] <= beat_wdata;
  end

  always_comb begin
    rd_word = rd_sel ? beats[rd_idx][63:32] : beats[rd_idx][31:0];
  end

endmodule

// File: rtl/ibus_fetch_responder.sv
// Instruction-bus responder: serves 32-bit fetches from a one-line buffer, refilling via cbus bursts.
module ibus_fetch_responder
  import ibus_fetch_responder_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush,
  output logic       busy
);

  localparam int unsigned OFFS  = $clog2(LINE_BEATS * 8);
  localparam int unsigned TAG_W = 64 - OFFS;
  localparam int unsigned IDX_W = $clog2(LINE_BEATS);

  fetch_state_t     state_q, state_d;
  logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic             tag_load, valid_clr, valid_set, beat_we;
  logic [TAG_W-1:0] line_tag;
  logic             line_valid;
  logic [31:0]      rd_word;
  logic             hit;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_sel;
  logic             unused_addr;

  assign req_tag     = ireq.addr[63:OFFS];
  assign req_idx     = ireq.addr[OFFS-1:3];
  assign req_sel     = ireq.addr[2];
  assign unused_addr = ^ireq.addr[1:0];

  assign hit = line_valid & ~flush & (req_tag == line_tag);

  fetch_line_buf #(
    .LINE_BEATS(LINE_BEATS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_load  (tag_load),
    .tag_in    (req_tag),
    .valid_clr (valid_clr),
    .valid_set (valid_set),
    .beat_we   (beat_we),
    .beat_widx (beat_cnt_q),
    .beat_wdata(cresp.data),
    .rd_idx    (req_idx),
    .rd_sel    (req_sel),
    .rd_word   (rd_word),
    .line_tag  (line_tag),
    .line_valid(line_valid)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    flush_pend_d = flush_pend_q;
    resp_data_d  = resp_data_q;
    tag_load     = 1'b0;
    valid_clr    = 1'b0;
    valid_set    = 1'b0;
    beat_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_clr = flush;
        if (ireq.valid) begin
          if (hit) begin
            state_d     = RESP;
            resp_data_d = rd_word;
          end else begin
            // The line is overwritten beat by beat, so it must stop hitting now.
            state_d      = REFILL;
            tag_load     = 1'b1;
            valid_clr    = 1'b1;
            beat_cnt_d   = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      RESP: begin
        valid_clr = flush;
        state_d   = IDLE;
      end
      REFILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (cresp.ready) begin
          beat_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + IDX_W'(1);
          if (cresp.last) begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
            valid_set    = ~flush_pend_q & ~flush;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_pend_q <= flush_pend_d;
      resp_data_q  <= resp_data_d;
    end
  end

  always_comb begin
    iresp.addr_ok = (state_q == RESP);
    iresp.data_ok = (state_q == RESP);
    iresp.data    = resp_data_q;
    // Request fields derive only from the latched tag, so they hold for the whole burst.
    creq.valid    = (state_q == REFILL);
    creq.is_write = 1'b0;
    creq.addr     = {line_tag, {OFFS{1'b0}}};
    creq.size     = MSIZE8;
    creq.len      = 8'(LINE_BEATS - 1);
    creq.burst    = AXI_BURST_INCR;
    creq.strobe   = '0;
    busy          = (state_q == REFILL);
  end

endmodule

// File: tb/tb_ibus_fetch_responder.sv
// Self-checking bench for ibus_fetch_responder with a data scoreboard and a burst memory model.
module tb_ibus_fetch_responder;
  import ibus_fetch_responder_pkg::*;

  localparam int unsigned LINE_BEATS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  int          n;

  always #5 clk = ~clk;

  ibus_fetch_responder #(.LINE_BEATS(LINE_BEATS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ireq (ireq),
    .iresp(iresp),
    .creq (creq),
    .cresp(cresp),
    .flush(flush),
    .busy (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [63:0] line, input int k, input int gen);
    return {8'hC0 + 8'(gen), 8'(k), 16'hBEEF, line[31:0] + 32'(k * 8)};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] addr, input int gen);
    logic [63:0] line = {addr[63:5], 5'b0};
    logic [63:0] v = beat_val(line, int'(addr[4:3]), gen);
    return addr[2] ? v[63:32] : v[31:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic present(input logic [63:0] addr, input bit expect_data, input int gen);
    ireq.valid = 1'b1;
    ireq.addr  = addr;
    if (expect_data) sb_q.push_back(exp_word(addr, gen));
  endtask

  task automatic wait_creq(output int cyc);
    cyc = 0;
    while (!creq.valid && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq("creq_valid", creq.valid, 1'b1);
  endtask

  task automatic wait_ok(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!iresp.data_ok && cyc < 40);
  endtask

  task automatic serve(input logic [63:0] line, input int gen, input int flush_beat,
                       input int drop_beat);
    for (int k = 0; k < int'(LINE_BEATS); k++) begin
      check_eq("creq_addr_stable", creq.addr, line);
      cresp.ready = 1'b1;
      cresp.last  = (k == int'(LINE_BEATS) - 1);
      cresp.data  = beat_val(line, k, gen);
      flush       = (k == flush_beat);
      if (k == drop_beat) ireq.valid = 1'b0;
      step();
    end
    cresp = '0;
    flush = 1'b0;
  endtask

  // Scoreboard: every data_ok pops one expected word.
  always @(negedge clk) begin
    if (rst_n && iresp.data_ok) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_data_ok", iresp.data_ok, 1'b0);
      end else begin
        check_eq("data", iresp.data, sb_q.pop_front());
        check_eq("addr_ok", iresp.addr_ok, 1'b1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    ireq  = '0;
    cresp = '0;
    repeat (2) step();
    check_eq("rst_data_ok", iresp.data_ok, 1'b0);
    check_eq("rst_addr_ok", iresp.addr_ok, 1'b0);
    check_eq("rst_data", iresp.data, 32'h0);
    check_eq("rst_creq_valid", creq.valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    // Cold miss
    present(64'h8000_0004, 1'b1, 0);
    wait_creq(n);
    check_eq("creq_addr", creq.addr, 64'h8000_0000);
    check_eq("creq_len", creq.len, 8'd3);
    check_eq("creq_size", creq.size, MSIZE8);
    check_eq("creq_burst", creq.burst, AXI_BURST_INCR);
    check_eq("creq_is_write", creq.is_write, 1'b0);
    check_eq("creq_strobe", creq.strobe, 8'h0);
    check_eq("busy_refill", busy, 1'b1);
    serve(64'h8000_0000, 0, -1, -1);
    wait_ok(n);
    check_eq("miss_latency", n + 1, 2);

    // Hit from IDLE
    ireq.valid = 1'b0;
    step();
    present(64'h8000_0018, 1'b1, 0);
    wait_ok(n);
    check_eq("hit_latency", n, 1);
    check_eq("hit_no_creq", creq.valid, 1'b0);

    // Back-to-back hits
    ireq.valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      present(64'h8000_0000 + 64'(4 * i), 1'b1, 0);
      wait_ok(n);
      check_eq("b2b_latency", n, (i == 0) ? 1 : 2);
    end

    // Flush during refill forces a second burst
    ireq.valid = 1'b0;
    step();
    present(64'h8000_1010, 1'b1, 2);
    wait_creq(n);
    serve(64'h8000_1000, 1, 2, -1);
    wait_creq(n);
    check_eq("reissue_latency", n, 1);
    check_eq("reissue_addr", creq.addr, 64'h8000_1000);
    serve(64'h8000_1000, 2, -1, -1);
    wait_ok(n);
    check_eq("reissue_miss_latency", n + 1, 2);

    // Abandoned fetch: burst completes, no data_ok, line then hits
    ireq.valid = 1'b0;
    step();
    present(64'h8000_2008, 1'b0, 3);
    wait_creq(n);
    serve(64'h8000_2000, 3, -1, 1);
    repeat (4) step();
    check_eq("abandon_no_data_ok", iresp.data_ok, 1'b0);
    check_eq("abandon_idle", busy, 1'b0);
    present(64'h8000_200C, 1'b1, 3);
    wait_ok(n);
    check_eq("abandon_hit_latency", n, 1);
    check_eq("abandon_hit_no_creq", creq.valid, 1'b0);

    // Async reset mid-burst
    ireq.valid = 1'b0;
    step();
    present(64'h8000_3000, 1'b0, 4);
    wait_creq(n);
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = beat_val(64'h8000_3000, 0, 4);
    step();
    cresp.data = beat_val(64'h8000_3000, 1, 4);
    check_eq("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("areset_creq_valid", creq.valid, 1'b0);
    check_eq("areset_busy", busy, 1'b0);
    check_eq("areset_data_ok", iresp.data_ok, 1'b0);
    cresp      = '0;
    ireq.valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    present(64'h8000_0004, 1'b1, 5);
    wait_creq(n);
    check_eq("post_reset_miss", n, 1);
    serve(64'h8000_0000, 5, -1, -1);
    wait_ok(n);
    check_eq("post_reset_miss_latency", n + 1, 2);
    ireq.valid = 1'b0;
    step();

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
